// File: rtl/mtimer_pkg.sv
// Shared definitions for the RISC-V machine timer: register offsets,
// reset values and the default bus window base address.
`ifndef XLEN
`define XLEN 32
`endif

package mtimer_pkg;

  // Word offsets within the 16-byte register window, taken from addr[3:2].
  typedef enum logic [1:0] {
    MTIME_LO    = 2'd0,
    MTIME_HI    = 2'd1,
    MTIMECMP_LO = 2'd2,
    MTIMECMP_HI = 2'd3
  } reg_off_e;

  localparam logic [63:0] MTIMECMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0200_0000;
  localparam int unsigned WINDOW_BYTES      = 16;

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides the clock down to an mtime increment strobe: o_tick is high in
// the cycle the count equals PRESCALE-1, after which the count wraps to 0.
module mtimer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign o_tick = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      count <= '0;
    end else if (i_clr || o_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a one-cycle request/ack
// bus, producing the registered machine timer-interrupt-pending level.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int unsigned       PRESCALE  = 1,
  parameter logic [`XLEN-1:0]  BASE_ADDR = `XLEN'(BASE_ADDR_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [`XLEN-1:0]  i_addr,
  input  logic [`XLEN-1:0]  i_wdata,
  output logic [`XLEN-1:0]  o_rdata,
  output logic              o_ack,
  output logic              o_sel,
  output logic              o_Int_tip
);

  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic [31:0]      hi_shadow;
  logic [`XLEN-1:0] rel_addr;
  logic [1:0]       off;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic             mtime_wr;
  logic             tick;
  logic [31:0]      rd_val;

  // Unsigned distance from the base makes the window check wrap-safe.
  assign rel_addr = i_addr - BASE_ADDR;
  assign o_sel    = (rel_addr < `XLEN'(WINDOW_BYTES));
  assign off      = i_addr[3:2];
  assign accept   = i_req && o_sel;
  assign wr_en    = accept && i_we;
  assign rd_en    = accept && !i_we;
  assign mtime_wr = wr_en && (off == MTIME_LO || off == MTIME_HI);

  mtimer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (mtime_wr),
    .o_tick (tick)
  );

  // NOTE: rd_val gets its default before the case so no path infers a latch.
  always_comb begin
    rd_val = '0;
    case (reg_off_e'(off))
      MTIME_LO:    rd_val = mtime[31:0];
      MTIME_HI:    rd_val = hi_shadow;
      MTIMECMP_LO: rd_val = mtimecmp[31:0];
      MTIMECMP_HI: rd_val = mtimecmp[63:32];
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      hi_shadow <= '0;
      o_ack     <= 1'b0;
      o_rdata   <= '0;
      o_Int_tip <= 1'b0;
    end else begin
      o_ack   <= accept;
      o_rdata <= rd_en ? `XLEN'(rd_val) : '0;

      // Reading the low half freezes the high half for the following read.
      if (rd_en && off == MTIME_LO) begin
        hi_shadow <= mtime[63:32];
      end

      // A software write beats a coincident tick; the increment is dropped.
      if (wr_en && off == MTIME_LO) begin
        mtime[31:0] <= i_wdata[31:0];
      end else if (wr_en && off == MTIME_HI) begin
        mtime[63:32] <= i_wdata[31:0];
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_en && off == MTIMECMP_LO) begin
        mtimecmp[31:0] <= i_wdata[31:0];
      end else if (wr_en && off == MTIMECMP_HI) begin
        mtimecmp[63:32] <= i_wdata[31:0];
      end

      o_Int_tip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped RISC-V machine timer: 64-bit mtime counter and 64-bit mtimecmp compare register.
- Drives the machine timer-interrupt-pending line into the CSR block's i_Int_tip input, which the CSR reflects as mip.MTIP.
- Sits on the data-memory bus as a slave, with one-cycle request/acknowledge.
- Only the producer of MTIP; enabling and masking (mie.MTIE, mstatus.MIE) stay in the CSR block.

Parameters:
- PRESCALE, 1: clock cycles per mtime increment; legal range 1..65535.
- BASE_ADDR, 32'h0200_0000: byte base address of the 16-byte register window.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low
- i_req  in  1  bus request strobe, one cycle per access
- i_we  in  1  1 = write, 0 = read; sampled with i_req
- i_addr  in  `XLEN  byte address; decoded against BASE_ADDR
- i_wdata  in  `XLEN  write data
- o_rdata  out  `XLEN  read data, valid when o_ack=1
- o_ack  out  1  access complete; asserted exactly one cycle after the i_req cycle
- o_sel  out  1  combinational: i_addr falls in [BASE_ADDR, BASE_ADDR+15]
- o_Int_tip  out  1  registered timer interrupt pending; connects to csr i_Int_tip

Behaviour:
- Reset (i_rst=0 at posedge):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, hi_shadow=0.
  - o_ack=0, o_rdata=0, o_Int_tip=0.
  - Reset mid-access drops the access; no ack is issued.
- Register map (offset = i_addr[3:2], word accesses only, i_addr[1:0] ignored):
  - 0: mtime[31:0]
  - 1: mtime[63:32]
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32]
- Access rules:
  - Request accepted only when i_req=1 and o_sel=1; i_req with o_sel=0 is ignored (no ack).
  - Back-to-back requests allowed, one per cycle; each produces o_ack one cycle later.
  - o_rdata=0 whenever o_ack=0.
- Prescaler:
  - Counts 0..PRESCALE-1. Tick asserted in the cycle the count equals PRESCALE-1, then it wraps to 0.
  - PRESCALE=1 gives a tick every cycle.
  - On a tick, mtime <= mtime+1 (64-bit, wraps FFFF..FF -> 0 with no flag).
- mtime writes:
  - A write to offset 0 or 1 replaces that half. The other half keeps its current value with no increment applied that cycle.
  - The write wins over a simultaneous tick: the increment is lost.
  - The write also clears the prescaler to 0.
- mtimecmp write: replaces the addressed half and does not affect mtime or the prescaler.
- Atomic 64-bit read:
  - A read of offset 0 returns mtime[31:0] and latches mtime[63:32] into hi_shadow in the same cycle.
  - A read of offset 1 returns hi_shadow, not live mtime[63:32].
  - Software reads lo then hi.
- Read values are sampled at the request cycle and presented with o_ack.
- Interrupt:
  - o_Int_tip <= (mtime >= mtimecmp), unsigned 64-bit, registered every cycle.
  - Level signal: stays high until software raises mtimecmp or lowers mtime.
  - After a write, the comparison uses the updated register value one cycle after the write cycle, so o_Int_tip changes two cycles after the request.
- Writing mtimecmp halves non-atomically may produce a transient spurious interrupt. This is architecturally permitted; software writes hi=FFFFFFFF first.

Decomposition:
- Shared package mtimer_pkg:
  - offset constants MTIME_LO=2'd0, MTIME_HI=2'd1, MTIMECMP_LO=2'd2, MTIMECMP_HI=2'd3
  - MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF
  - BASE_ADDR default, for the bus decoder in the top level
- One natural sub-module, mtimer_prescaler: parameter PRESCALE; ports i_clk, i_rst, i_clr, o_tick.
- Register file, shadow, compare and bus logic stay in mtimer.

Test Plan:
- Reset then idle 10 cycles, PRESCALE=1 -> o_Int_tip=0; read offset 0 returns 10 (+/-1 per sampling cycle); o_ack one cycle after each i_req.
- PRESCALE=4, run 40 cycles after reset -> mtime read = 10; writing mtime lo = 0 clears the prescaler, so the next increment comes 4 cycles later.
- Write mtimecmp hi=0, lo=20 with PRESCALE=1 -> o_Int_tip rises in the cycle after mtime reaches 20 and stays high; writing mtimecmp lo=1000 drops o_Int_tip two cycles after that request.
- Write mtime hi=0, lo=FFFF_FFFF, then read lo, wait 5 cycles, read hi -> lo=FFFF_FFFF (or +1 carry case captured), hi equals the value latched at the lo read (0 or 1), not the live value.
- Write mtime=FFFF_FFFF_FFFF_FFFF -> wraps to 0 on the next tick; with mtimecmp=FFFF_FFFF_FFFF_FFFF, o_Int_tip is 1 for exactly one cycle at the all-ones value, then 0.
- Concurrency and decode:
  - Write to offset 0 in a tick cycle -> written value held, increment lost.
  - i_req with address BASE_ADDR+16 -> no o_ack, no state change.
  - Assert i_rst=0 during an access -> o_ack=0, all registers return to reset values.
